// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO burst reader.
// The optional popped-word counter is enabled by FIFO_BURST_READER_CNT_EN.
package fifo_rd_pkg;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_LEN_W  = 4;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO read port and downstream stream bundle for the burst reader.
// master = the reader itself, slave = its surroundings (FIFO, consumer, controller).
interface fifo_burst_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
);

    logic              rd_start;
    logic [LEN_W-1:0]  rd_len;
    logic              busy;
    logic              done;
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  rd_start, rd_len, fifo_empty, fifo_data, m_ready,
        output busy, done, fifo_r_en, m_valid, m_data, m_last
    );

    modport slave (
        output rd_start, rd_len, fifo_empty, fifo_data, m_ready,
        input  busy, done, fifo_r_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order buffer holding words (plus their last tag) captured
// from the FIFO until the downstream consumer accepts them.
module fifo_rd_skid #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_last,
    output logic [1:0]   occ
);

    logic [W-1:0] data_q [2];
    logic         last_q [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage and pointers; a simultaneous push and pop leaves occupancy as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a requested number of words from the FIFO and streams them out with m_last.
// Define FIFO_BURST_READER_CNT_EN to add the rd_count total-pops counter port.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic clk,
    input  logic rst,
    fifo_burst_reader_if.master bus
`ifdef FIFO_BURST_READER_CNT_EN
    ,
    output logic [CNT_W-1:0] rd_count
`endif
);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [LEN_W-1:0]  left;
    logic              pend;
    logic              pend_last;
    logic [1:0]        occ;
    logic [2:0]        inflight;
    logic              pop;
    logic              issue;
    logic              m_valid_int;
    logic [DATA_W-1:0] head_data;
    logic              head_last;

    assign m_valid_int = (occ != 2'd0);
    assign pop         = m_valid_int && bus.m_ready;
    assign inflight    = {1'b0, occ} + {2'b0, pend};

    // Room check is inflight - pop < 2, rewritten to avoid unsigned underflow.
    assign issue = (state == RUN) && !bus.fifo_empty &&
                   ((inflight < 3'd2) || (pop && (inflight < 3'd3)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rd_start) begin
                    state_nxt = (bus.rd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && (left == LEN_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pend && (occ == 2'd0) && !pop) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pend marks a read whose data lands on fifo_data during the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left      <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend      <= issue;
            pend_last <= issue && (left == LEN_W'(1));
            if ((state == IDLE) && bus.rd_start) begin
                left <= bus.rd_len;
            end else if (issue) begin
                left <= left - LEN_W'(1);
            end
        end
    end

    fifo_rd_skid #(
        .W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pend),
        .push_data (bus.fifo_data),
        .push_last (pend_last),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .occ       (occ)
    );

    assign bus.busy      = (state == RUN) || (state == DRAIN);
    assign bus.done      = (state == DONE);
    assign bus.fifo_r_en = issue;
    assign bus.m_valid   = m_valid_int;
    assign bus.m_data    = head_data;
    assign bus.m_last    = m_valid_int && head_last;

`ifdef FIFO_BURST_READER_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized and directed bench for fifo_burst_reader against a queue-based
// transaction model; covers rd_count when FIFO_BURST_READER_CNT_EN is defined.
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    localparam int DATA_W = 2;
    localparam int LEN_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                last;
        int                cap;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;

    fifo_burst_reader_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef FIFO_BURST_READER_CNT_EN
    logic [15:0] rd_count;
`endif

    fifo_burst_reader #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIFO_BURST_READER_CNT_EN
        ,
        .rd_count (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // Model state: phase 0 idle, 1 busy, 2 done; mq holds words read but not yet popped.
    logic [DATA_W-1:0] fifo_q [$];
    word_t mq [$];
    int phase = 0;
    int left_m = 0;
    int edge_cnt = 0;
    int model_pops = 0;

    int chk = 0;
    int err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ren_cnt = 0;
    int done_cnt = 0;
    logic [DATA_W-1:0] pop_data [$];
    bit pop_last [$];
    int pop_cyc [$];

    function bit m_valid_exp();
        return (mq.size() > 0) && (mq[0].cap <= edge_cnt);
    endfunction

    function bit r_en_exp();
        int p;
        p = (m_valid_exp() && bus.m_ready) ? 1 : 0;
        return (phase == 1) && (left_m > 0) && !bus.fifo_empty && ((mq.size() - p) < 2);
    endfunction

    // Bench FIFO (registered data_out) plus the transaction model, advanced each edge.
    always @(posedge clk or posedge rst) begin : model_blk
        bit ev;
        bit er;
        bit pop;
        int pre_size;
        word_t w;
        if (rst) begin
            mq.delete();
            phase      <= 0;
            left_m     <= 0;
            model_pops <= 0;
            bus.fifo_empty <= (fifo_q.size() == 0);
        end else begin
            ev = m_valid_exp();
            er = r_en_exp();
            pop = ev && bus.m_ready;
            pre_size = mq.size();
            case (phase)
                0: begin
                    if (bus.rd_start) begin
                        if (bus.rd_len == '0) begin
                            phase <= 2;
                        end else begin
                            phase  <= 1;
                            left_m <= int'(bus.rd_len);
                        end
                    end
                end
                1: begin
                    if (pop) begin
                        void'(mq.pop_front());
                        model_pops <= model_pops + 1;
                    end
                    if (er) begin
                        w.data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
                        w.last = (left_m == 1);
                        w.cap  = edge_cnt + 2;
                        mq.push_back(w);
                        left_m <= left_m - 1;
                    end
                    if ((left_m == 0) && (pre_size == 0)) begin
                        phase <= 2;
                    end
                end
                default: phase <= 0;
            endcase
            edge_cnt <= edge_cnt + 1;
            if (bus.fifo_r_en && (fifo_q.size() > 0)) begin
                bus.fifo_data <= fifo_q.pop_front();
            end
            if (wr_en) begin
                fifo_q.push_back(wr_data);
            end
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic applyStimulus(input int len);
        bus.rd_len   = LEN_W'(len);
        bus.rd_start = 1'b1;
        tick(1);
        bus.rd_start = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        while ((phase != 0 || bus.busy || bus.done) && (n < budget)) begin
            tick(1);
            n++;
        end
        checkOutput({name, "_timeout"}, (n >= budget) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic checkPins(input string tag);
        checkOutput({tag, "_busy"}, bus.busy, 32'd0);
        checkOutput({tag, "_done"}, bus.done, 32'd0);
        checkOutput({tag, "_fifo_r_en"}, bus.fifo_r_en, 32'd0);
        checkOutput({tag, "_m_valid"}, bus.m_valid, 32'd0);
        checkOutput({tag, "_m_data"}, bus.m_data, 32'd0);
        checkOutput({tag, "_m_last"}, bus.m_last, 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] exp_a [4];
        logic [DATA_W-1:0] exp_w [$];
        int mark;
        int dmark;
        int rmark;
        int n;
        int len;
        int pushed;

        bus.rd_start = 1'b0;
        bus.rd_len   = '0;
        bus.m_ready  = 1'b0;

        // Compare process: every cycle, DUT outputs against the model.
        fork
            forever begin
                @(negedge clk);
                cyc++;
                checkOutput("busy", bus.busy, (phase == 1));
                checkOutput("done", bus.done, (phase == 2));
                checkOutput("fifo_r_en", bus.fifo_r_en, r_en_exp());
                checkOutput("m_valid", bus.m_valid, m_valid_exp());
                if (m_valid_exp()) begin
                    checkOutput("m_data", bus.m_data, mq[0].data);
                    checkOutput("m_last", bus.m_last, mq[0].last);
                end
`ifdef FIFO_BURST_READER_CNT_EN
                if (!rst) begin
                    checkOutput("rd_count", rd_count, model_pops[15:0]);
                end
`endif
                if (bus.rd_start && (phase == 0)) start_cyc = cyc;
                if (bus.fifo_r_en) ren_cnt++;
                if (bus.done) done_cnt++;
                if (bus.m_valid && bus.m_ready) begin
                    pop_data.push_back(bus.m_data);
                    pop_last.push_back(bus.m_last);
                    pop_cyc.push_back(cyc);
                end
            end
        join_none

        #1 rst = 1'b1;
        tick(2);
        checkPins("reset");
        rst = 1'b0;
        tick(1);

        // Preloaded 1,2,3,0 with m_ready held high.
        exp_a[0] = 2'd1; exp_a[1] = 2'd2; exp_a[2] = 2'd3; exp_a[3] = 2'd0;
        for (int i = 0; i < 4; i++) pushWord(exp_a[i]);
        bus.m_ready = 1'b1;
        mark = pop_data.size();
        dmark = done_cnt;
        applyStimulus(4);
        waitIdle(40, "burst4");
        checkOutput("burst4_count", pop_data.size() - mark, 32'd4);
        if (pop_data.size() - mark == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("burst4_data", pop_data[mark + i], exp_a[i]);
                checkOutput("burst4_last", pop_last[mark + i], (i == 3) ? 32'd1 : 32'd0);
            end
            for (int i = 1; i < 4; i++) begin
                checkOutput("burst4_back2back", pop_cyc[mark + i] - pop_cyc[mark + i - 1], 32'd1);
            end
            checkOutput("burst4_latency", pop_cyc[mark] - start_cyc, 32'd3);
        end
        checkOutput("burst4_done_pulses", done_cnt - dmark, 32'd1);

        // Zero-length burst: no reads, one done pulse.
        rmark = ren_cnt;
        dmark = done_cnt;
        applyStimulus(0);
        waitIdle(10, "len0");
        checkOutput("len0_reads", ren_cnt - rmark, 32'd0);
        checkOutput("len0_done_pulses", done_cnt - dmark, 32'd1);

        // Downstream backpressure for 5 cycles mid-burst.
        exp_w.delete();
        for (int i = 0; i < 6; i++) begin
            exp_w.push_back(DATA_W'($urandom_range(0, 3)));
            pushWord(exp_w[i]);
        end
        mark = pop_data.size();
        applyStimulus(6);
        n = 0;
        while ((pop_data.size() - mark < 2) && (n < 20)) begin
            tick(1);
            n++;
        end
        bus.m_ready = 1'b0;
        tick(5);
        bus.m_ready = 1'b1;
        waitIdle(40, "stall");
        checkOutput("stall_count", pop_data.size() - mark, 32'd6);
        if (pop_data.size() - mark == 6) begin
            for (int i = 0; i < 6; i++) checkOutput("stall_data", pop_data[mark + i], exp_w[i]);
        end

        // FIFO runs dry after 2 of 5 words, refilled later.
        exp_w.delete();
        for (int i = 0; i < 5; i++) exp_w.push_back(DATA_W'($urandom_range(0, 3)));
        pushWord(exp_w[0]);
        pushWord(exp_w[1]);
        mark = pop_data.size();
        applyStimulus(5);
        tick(6);
        for (int i = 2; i < 5; i++) pushWord(exp_w[i]);
        waitIdle(40, "refill");
        checkOutput("refill_count", pop_data.size() - mark, 32'd5);
        if (pop_data.size() - mark == 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("refill_data", pop_data[mark + i], exp_w[i]);
                checkOutput("refill_last", pop_last[mark + i], (i == 4) ? 32'd1 : 32'd0);
            end
        end

        // A second start during the burst must be ignored.
        for (int i = 0; i < 6; i++) pushWord(DATA_W'(i));
        mark = pop_data.size();
        dmark = done_cnt;
        applyStimulus(3);
        applyStimulus(5);
        waitIdle(40, "restart");
        checkOutput("restart_count", pop_data.size() - mark, 32'd3);
        checkOutput("restart_done_pulses", done_cnt - dmark, 32'd1);

        // Reset after three pops of an 8-word burst, then a fresh 2-word burst.
        for (int i = 0; i < 8; i++) pushWord(DATA_W'($urandom_range(0, 3)));
        mark = pop_data.size();
        applyStimulus(8);
        n = 0;
        while ((pop_data.size() - mark < 3) && (n < 30)) begin
            tick(1);
            n++;
        end
        rst = 1'b1;
        #1;
        checkPins("midreset");
        tick(2);
        rst = 1'b0;
        tick(1);
        mark = pop_data.size();
        applyStimulus(2);
        waitIdle(30, "post_reset");
        checkOutput("post_reset_count", pop_data.size() - mark, 32'd2);
        if (pop_data.size() - mark == 2) begin
            checkOutput("post_reset_last", pop_last[mark + 1], 32'd1);
        end

        // Random bursts with random backpressure and FIFO refills.
        for (int b = 0; b < 30; b++) begin
            len = $urandom_range(0, 15);
            pushed = $urandom_range(0, len);
            for (int i = 0; i < pushed; i++) pushWord(DATA_W'($urandom_range(0, 3)));
            applyStimulus(len);
            n = 0;
            while ((phase != 0 || bus.busy || bus.done) && (n < 400)) begin
                bus.m_ready = ($urandom_range(0, 3) != 0);
                if ((pushed < len) && ($urandom_range(0, 2) == 0)) begin
                    wr_en   = 1'b1;
                    wr_data = DATA_W'($urandom_range(0, 3));
                    pushed++;
                end else begin
                    wr_en = 1'b0;
                end
                tick(1);
                n++;
            end
            wr_en = 1'b0;
            bus.m_ready = 1'b1;
            checkOutput("random_timeout", (n >= 400) ? 32'd1 : 32'd0, 32'd0);
        end

        tick(3);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
